// File: rtl/hub75_bcm_scan.sv
// HUB75 LED panel scanner: per-row, per-bit-plane binary code modulation.
// Shifts one plane of a line pair, latches it, then shows it for a weighted on-time.
module hub75_bcm_scan #(
    parameter int unsigned HPIXEL_P = 64,
    parameter int unsigned VPIXEL_P = 64,
    parameter int unsigned BPP_P    = 8,
    localparam int unsigned SROWS   = VPIXEL_P / 2,
    localparam int unsigned ROW_W   = (SROWS > 1) ? $clog2(SROWS) : 1,
    localparam int unsigned ADDR_W  = (HPIXEL_P * SROWS > 1) ? $clog2(HPIXEL_P * SROWS) : 1,
    localparam int unsigned CNT_W   = 8 + BPP_P
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_en,
    input  logic [7:0]                   i_brightness,
    output logic [ADDR_W-1:0]            o_rd_addr,
    input  logic [1:0][2:0][BPP_P-1:0]   i_rd_data,
    output logic                         O_CLK,
    output logic                         STB,
    output logic                         OE,
    output logic [ROW_W-1:0]             o_row,
    output logic                         R1,
    output logic                         G1,
    output logic                         B1,
    output logic                         R2,
    output logic                         G2,
    output logic                         B2,
    output logic                         o_busy,
    output logic                         o_frame_done
);

    localparam int unsigned COL_W = (HPIXEL_P > 1) ? $clog2(HPIXEL_P) : 1;
    localparam int unsigned PL_W  = (BPP_P > 1) ? $clog2(BPP_P) : 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFETCH = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_BLANK    = 3'd3,
        ST_LATCH    = 3'd4,
        ST_DISPLAY  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [PL_W-1:0]     plane_q, plane_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                phase_q, phase_d;
    logic [CNT_W-1:0]    disp_q, disp_d;
    logic [7:0]          br_q, br_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                oclk_q, oclk_d;
    logic                stb_q, stb_d;
    logic                oe_q, oe_d;
    logic [ROW_W-1:0]    orow_q, orow_d;
    logic [5:0]          rgb_q, rgb_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [CNT_W-1:0]    disp_load;
    logic                last_col;
    logic                last_plane;
    logic                last_row;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ROW_W-1:0] r,
                                                   input logic [COL_W-1:0] c);
        return ADDR_W'(32'(r) * HPIXEL_P + 32'(c));
    endfunction

    // Next state; registered outputs are computed for the state being entered.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        plane_d   = plane_q;
        col_d     = col_q;
        phase_d   = phase_q;
        disp_d    = disp_q;
        br_d      = br_q;
        addr_d    = addr_q;
        orow_d    = orow_q;
        rgb_d     = rgb_q;
        oclk_d    = 1'b0;
        stb_d     = 1'b0;
        oe_d      = 1'b1;
        done_d    = 1'b0;

        disp_load  = ((CNT_W'(br_q) + CNT_W'(1)) << plane_q) - CNT_W'(1);
        last_col   = (col_q == COL_W'(HPIXEL_P - 1));
        last_plane = (plane_q == PL_W'(BPP_P - 1));
        last_row   = (row_q == ROW_W'(SROWS - 1));

        case (state_q)
            ST_IDLE: begin
                if (i_en) begin
                    state_d = ST_PREFETCH;
                    row_d   = '0;
                    plane_d = '0;
                    br_d    = i_brightness;
                    addr_d  = pix_addr('0, '0);
                end
            end
            ST_PREFETCH: begin
                state_d = ST_SHIFT;
                col_d   = '0;
                phase_d = 1'b0;
            end
            ST_SHIFT: begin
                if (!phase_q) begin
                    // Data for this column arrives now; present it while O_CLK is high.
                    rgb_d   = {i_rd_data[1][0][plane_q], i_rd_data[1][1][plane_q],
                               i_rd_data[1][2][plane_q], i_rd_data[0][0][plane_q],
                               i_rd_data[0][1][plane_q], i_rd_data[0][2][plane_q]};
                    phase_d = 1'b1;
                    oclk_d  = 1'b1;
                    addr_d  = pix_addr(row_q, last_col ? col_q : col_q + COL_W'(1));
                end else if (last_col) begin
                    state_d = ST_BLANK;
                    orow_d  = row_q;
                end else begin
                    col_d   = col_q + COL_W'(1);
                    phase_d = 1'b0;
                end
            end
            ST_BLANK: begin
                state_d = ST_LATCH;
                stb_d   = 1'b1;
            end
            ST_LATCH: begin
                state_d = ST_DISPLAY;
                oe_d    = 1'b0;
                disp_d  = disp_load;
                done_d  = last_plane && last_row && (disp_load == '0);
            end
            ST_DISPLAY: begin
                if (disp_q != '0) begin
                    disp_d = disp_q - CNT_W'(1);
                    oe_d   = 1'b0;
                    done_d = last_plane && last_row && (disp_q == CNT_W'(1));
                end else if (!last_plane) begin
                    state_d = ST_PREFETCH;
                    plane_d = plane_q + PL_W'(1);
                    addr_d  = pix_addr(row_q, '0);
                end else if (!last_row) begin
                    state_d = ST_PREFETCH;
                    row_d   = row_q + ROW_W'(1);
                    plane_d = '0;
                    addr_d  = pix_addr(row_q + ROW_W'(1), '0);
                end else if (i_en) begin
                    state_d = ST_PREFETCH;
                    row_d   = '0;
                    plane_d = '0;
                    br_d    = i_brightness;
                    addr_d  = pix_addr('0, '0);
                end else begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                    plane_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            plane_q <= '0;
            col_q   <= '0;
            phase_q <= 1'b0;
            disp_q  <= '0;
            br_q    <= '0;
            addr_q  <= '0;
            oclk_q  <= 1'b0;
            stb_q   <= 1'b0;
            oe_q    <= 1'b1;
            orow_q  <= '0;
            rgb_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            col_q   <= col_d;
            phase_q <= phase_d;
            disp_q  <= disp_d;
            br_q    <= br_d;
            addr_q  <= addr_d;
            oclk_q  <= oclk_d;
            stb_q   <= stb_d;
            oe_q    <= oe_d;
            orow_q  <= orow_d;
            rgb_q   <= rgb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_rd_addr    = addr_q;
    assign O_CLK        = oclk_q;
    assign STB          = stb_q;
    assign OE           = oe_q;
    assign o_row        = orow_q;
    assign {B2, G2, R2, B1, G1, R1} = rgb_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Directed bench for hub75_bcm_scan: a 4x4/2-plane panel with a framebuffer
// model, plus an 8-plane instance for the longest on-time.
module tb_hub75_bcm_scan;

    logic clk;
    logic rst_n;

    // Small panel: H=4, V=4 (2 scan rows), 2 planes.
    logic                   i_en;
    logic [7:0]             i_brightness;
    logic [2:0]             o_rd_addr;
    logic [1:0][2:0][1:0]   rd_data;
    logic                   O_CLK, STB, OE;
    logic [0:0]             o_row;
    logic                   R1, G1, B1, R2, G2, B2;
    logic                   o_busy, o_frame_done;

    // Long-plane panel: H=2, V=2 (1 scan row), 8 planes.
    logic                   en2;
    logic [7:0]             br2;
    logic [0:0]             addr2;
    logic [1:0][2:0][7:0]   rd2;
    logic                   oclk2, stb2, oe2;
    logic [0:0]             row2;
    logic                   r1b, g1b, b1b, r2b, g2b, b2b;
    logic                   busy2, done2;

    logic [1:0][2:0][1:0]   fb [8];

    int chk_cnt;
    int pass_cnt;

    // Capture results of one frame on the small panel.
    logic [5:0] cap [4][4];
    int         oe_len [4];
    int         ncols [4];
    logic       stb_row [4];
    bit         stb_pre [4];
    int         row_bad, lines, done_cyc, r1_hits, r1_line, r1_col;
    bit         cap_to;
    logic       first_busy;
    logic [2:0] first_addr;

    hub75_bcm_scan #(.HPIXEL_P(4), .VPIXEL_P(4), .BPP_P(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_brightness(i_brightness),
        .o_rd_addr(o_rd_addr), .i_rd_data(rd_data),
        .O_CLK(O_CLK), .STB(STB), .OE(OE), .o_row(o_row),
        .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
        .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    hub75_bcm_scan #(.HPIXEL_P(2), .VPIXEL_P(2), .BPP_P(8)) dut_long (
        .clk(clk), .rst_n(rst_n), .i_en(en2), .i_brightness(br2),
        .o_rd_addr(addr2), .i_rd_data(rd2),
        .O_CLK(oclk2), .STB(stb2), .OE(oe2), .o_row(row2),
        .R1(r1b), .G1(g1b), .B1(b1b), .R2(r2b), .G2(g2b), .B2(b2b),
        .o_busy(busy2), .o_frame_done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous framebuffer: data valid the cycle after the address.
    always @(posedge clk) rd_data <= fb[o_rd_addr];

    function automatic logic [5:0] exp_bits(input int row, input int col, input int pl);
        int a;
        a = row * 4 + col;
        return {fb[a][1][0][pl], fb[a][1][1][pl], fb[a][1][2][pl],
                fb[a][0][0][pl], fb[a][0][1][pl], fb[a][0][2][pl]};
    endfunction

    // Samples one frame at negedges, from its first busy cycle to o_frame_done.
    task automatic capture_frame(input int drop_en_at, input int chg_at, input logic [7:0] chg_val);
        int   n, col, line;
        bit   started, fin;
        logic prev_oe, prev_stb;
        for (int k = 0; k < 4; k++) begin
            oe_len[k] = 0; ncols[k] = 0; stb_row[k] = 1'b0; stb_pre[k] = 1'b0;
            for (int c = 0; c < 4; c++) cap[k][c] = 6'h3f;
        end
        row_bad = 0; lines = 0; done_cyc = 0; r1_hits = 0; r1_line = -1; r1_col = -1;
        cap_to = 1'b0; started = 1'b0; fin = 1'b0; n = 0; col = 0; line = 0;
        prev_oe = 1'b1; prev_stb = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin first_busy = o_busy; first_addr = o_rd_addr; end
            if (!started && o_busy) started = 1'b1;
            if (started) begin
                n++;
                if (n == drop_en_at) i_en = 1'b0;
                if (n == chg_at) i_brightness = chg_val;
                if (O_CLK) begin
                    if (line < 4 && col < 4) cap[line][col] = {B2, G2, R2, B1, G1, R1};
                    if (R1) begin r1_hits++; r1_line = line; r1_col = col; end
                    col++;
                end
                if (STB) begin
                    if (line < 4) begin stb_row[line] = o_row[0]; ncols[line] = col; end
                    col = 0;
                end
                if (!OE) begin
                    if (line < 4) begin
                        if (prev_oe) stb_pre[line] = prev_stb;
                        oe_len[line]++;
                        if (o_row[0] !== stb_row[line]) row_bad++;
                    end
                end else if (!prev_oe) begin
                    line++;
                end
                prev_oe = OE; prev_stb = STB;
                if (o_frame_done) begin done_cyc = n; lines = line + 1; fin = 1'b1; end
            end
        end
        if (!fin) cap_to = 1'b1;
    endtask

    task automatic test_reset;
        logic [14:0] obs, exp_v;
        bit active;
        rst_n = 1'b0; i_en = 1'b0; i_brightness = 8'd0; en2 = 1'b0; br2 = 8'd0;
        @(negedge clk);
        exp_v = {1'b0, 1'b0, 1'b1, 1'b0, 6'b0, 3'b0, 1'b0, 1'b0};
        obs = {O_CLK, STB, OE, o_row, R1, G1, B1, R2, G2, B2, o_rd_addr, o_busy, o_frame_done};
        chk_cnt++; if (obs !== exp_v) $display("FAIL reset_outputs got=%h want=%h", obs, exp_v); else pass_cnt++;
        chk_cnt++; if ({oe2, stb2, busy2} !== 3'b100) $display("FAIL reset_long got=%b want=100", {oe2, stb2, busy2}); else pass_cnt++;
        rst_n = 1'b1;
        active = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_busy || O_CLK || STB || !OE || o_frame_done) active = 1'b1;
        end
        chk_cnt++; if (active !== 1'b0) $display("FAIL idle_quiet got=%b want=0", active); else pass_cnt++;
    endtask

    task automatic test_single_pixel;
        for (int a = 0; a < 8; a++) fb[a] = '0;
        fb[6][0][2] = 2'b10;
        i_brightness = 8'd0;
        i_en = 1'b1;
        capture_frame(5, 0, 8'd0);
        chk_cnt++; if (cap_to !== 1'b0) $display("FAIL px_timeout got=%b want=0", cap_to); else pass_cnt++;
        chk_cnt++; if (done_cyc !== 50) $display("FAIL px_frame_len got=%0d want=50", done_cyc); else pass_cnt++;
        chk_cnt++; if (r1_hits !== 1) $display("FAIL px_r1_hits got=%0d want=1", r1_hits); else pass_cnt++;
        chk_cnt++; if (r1_line !== 3 || r1_col !== 2) $display("FAIL px_r1_where got=line%0d/col%0d want=line3/col2", r1_line, r1_col); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if ({o_busy, o_frame_done, OE} !== 3'b001) $display("FAIL px_idle got=%b want=001", {o_busy, o_frame_done, OE}); else pass_cnt++;
    endtask

    task automatic test_frame_pattern;
        logic [11:0] pat [8];
        int bad;
        pat[0] = 12'hA5C; pat[1] = 12'h3F1; pat[2] = 12'h96E; pat[3] = 12'h027;
        pat[4] = 12'hD48; pat[5] = 12'h7B3; pat[6] = 12'hE19; pat[7] = 12'h5C6;
        for (int a = 0; a < 8; a++) fb[a] = pat[a];
        i_brightness = 8'd0;
        i_en = 1'b1;
        capture_frame(0, 0, 8'd0);
        i_en = 1'b0;
        chk_cnt++; if (cap_to !== 1'b0) $display("FAIL pat_timeout got=%b want=0", cap_to); else pass_cnt++;
        chk_cnt++; if (done_cyc !== 50) $display("FAIL pat_frame_len got=%0d want=50", done_cyc); else pass_cnt++;
        chk_cnt++; if (lines !== 4) $display("FAIL pat_lines got=%0d want=4", lines); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            chk_cnt++; if (ncols[k] !== 4) $display("FAIL pat_ncols%0d got=%0d want=4", k, ncols[k]); else pass_cnt++;
            chk_cnt++; if (stb_row[k] !== 1'(k / 2)) $display("FAIL pat_row%0d got=%0d want=%0d", k, stb_row[k], k / 2); else pass_cnt++;
            chk_cnt++; if (oe_len[k] !== (1 << (k % 2))) $display("FAIL pat_oe%0d got=%0d want=%0d", k, oe_len[k], 1 << (k % 2)); else pass_cnt++;
            chk_cnt++; if (stb_pre[k] !== 1'b1) $display("FAIL pat_stb_pre%0d got=%b want=1", k, stb_pre[k]); else pass_cnt++;
            bad = 0;
            for (int c = 0; c < 4; c++) if (cap[k][c] !== exp_bits(k / 2, c, k % 2)) bad++;
            chk_cnt++; if (bad !== 0) $display("FAIL pat_bits_line%0d got=%0d_bad_cols want=0", k, bad); else pass_cnt++;
        end
        chk_cnt++; if (row_bad !== 0) $display("FAIL pat_row_stable got=%0d want=0", row_bad); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (o_busy !== 1'b0) $display("FAIL pat_idle got=%b want=0", o_busy); else pass_cnt++;
    endtask

    task automatic test_brightness_change;
        i_brightness = 8'd0;
        i_en = 1'b1;
        capture_frame(0, 20, 8'd3);
        chk_cnt++; if (cap_to !== 1'b0) $display("FAIL brc_timeout got=%b want=0", cap_to); else pass_cnt++;
        chk_cnt++; if ({oe_len[0], oe_len[1], oe_len[2], oe_len[3]} !== {32'd1, 32'd2, 32'd1, 32'd2})
            $display("FAIL brc_old_ontimes got=%0d,%0d,%0d,%0d want=1,2,1,2", oe_len[0], oe_len[1], oe_len[2], oe_len[3]); else pass_cnt++;
        capture_frame(0, 0, 8'd0);
        chk_cnt++; if (oe_len[0] !== 4) $display("FAIL brc_new_plane0 got=%0d want=4", oe_len[0]); else pass_cnt++;
        chk_cnt++; if ({oe_len[1], oe_len[2], oe_len[3]} !== {32'd8, 32'd4, 32'd8})
            $display("FAIL brc_new_ontimes got=%0d,%0d,%0d want=8,4,8", oe_len[1], oe_len[2], oe_len[3]); else pass_cnt++;
        chk_cnt++; if (done_cyc !== 68) $display("FAIL brc_frame_len got=%0d want=68", done_cyc); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        capture_frame(0, 0, 8'd0);
        chk_cnt++; if (first_busy !== 1'b1 || first_addr !== 3'd0) $display("FAIL b2b_restart got=busy%b/addr%0d want=busy1/addr0", first_busy, first_addr); else pass_cnt++;
        chk_cnt++; if (done_cyc !== 68) $display("FAIL b2b_period got=%0d want=68", done_cyc); else pass_cnt++;
        i_en = 1'b0;
        @(negedge clk);
        chk_cnt++; if (o_busy !== 1'b0) $display("FAIL b2b_stop got=%b want=0", o_busy); else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        logic [14:0] obs, exp_v;
        bit seen, glitch;
        exp_v = {1'b0, 1'b0, 1'b1, 1'b0, 6'b0, 3'b0, 1'b0, 1'b0};
        i_brightness = 8'd5;
        i_en = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                // Second row, so o_row and RGB are non-zero before the reset hits.
                if (pass == 0 && O_CLK && o_row[0] && R1) seen = 1'b1;
                if (pass == 1 && !OE && o_row[0]) seen = 1'b1;
            end
            chk_cnt++; if (seen !== 1'b1) $display("FAIL rst_mid%0d_reach got=%b want=1", pass, seen); else pass_cnt++;
            rst_n = 1'b0;
            #1;
            obs = {O_CLK, STB, OE, o_row, R1, G1, B1, R2, G2, B2, o_rd_addr, o_busy, o_frame_done};
            chk_cnt++; if (obs !== exp_v) $display("FAIL rst_mid%0d_outputs got=%h want=%h", pass, obs, exp_v); else pass_cnt++;
            glitch = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (STB || !OE || O_CLK || o_busy) glitch = 1'b1;
            end
            chk_cnt++; if (glitch !== 1'b0) $display("FAIL rst_mid%0d_glitch got=%b want=0", pass, glitch); else pass_cnt++;
            rst_n = 1'b1;
        end
        i_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_long_plane;
        int  run, len, row_bad2, frames;
        int  run_len [8];
        bit  pre [8];
        bit  fin, seen;
        logic prev_oe, prev_stb, row_at;
        for (int k = 0; k < 8; k++) begin run_len[k] = 0; pre[k] = 1'b0; end
        br2 = 8'd255;
        en2 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); if (busy2) seen = 1'b1; end
        en2 = 1'b0;
        chk_cnt++; if (seen !== 1'b1) $display("FAIL long_start got=%b want=1", seen); else pass_cnt++;
        run = 0; len = 0; row_bad2 = 0; frames = 0; fin = 1'b0;
        prev_oe = 1'b1; prev_stb = 1'b0; row_at = 1'b0;
        for (int cyc = 0; cyc < 70000 && !fin; cyc++) begin
            @(negedge clk);
            if (done2) frames++;
            if (!oe2) begin
                if (prev_oe) begin len = 0; row_at = row2[0]; if (run < 8) pre[run] = prev_stb; end
                len++;
                if (row2[0] !== row_at) row_bad2++;
            end else if (!prev_oe) begin
                if (run < 8) run_len[run] = len;
                run++;
            end
            prev_oe = oe2; prev_stb = stb2;
            if (!busy2) fin = 1'b1;
        end
        chk_cnt++; if (fin !== 1'b1) $display("FAIL long_timeout got=%b want=1", fin); else pass_cnt++;
        chk_cnt++; if (run !== 8) $display("FAIL long_runs got=%0d want=8", run); else pass_cnt++;
        chk_cnt++; if (run_len[0] !== 256) $display("FAIL long_plane0 got=%0d want=256", run_len[0]); else pass_cnt++;
        chk_cnt++; if (run_len[7] !== 32768) $display("FAIL long_plane7 got=%0d want=32768", run_len[7]); else pass_cnt++;
        chk_cnt++; if (pre[7] !== 1'b1) $display("FAIL long_stb_pre got=%b want=1", pre[7]); else pass_cnt++;
        chk_cnt++; if (row_bad2 !== 0) $display("FAIL long_row_stable got=%0d want=0", row_bad2); else pass_cnt++;
        chk_cnt++; if (frames !== 1) $display("FAIL long_frame_done got=%0d want=1", frames); else pass_cnt++;
    endtask

    initial begin
        chk_cnt = 0;
        pass_cnt = 0;
        rd2 = '0;
        for (int a = 0; a < 8; a++) fb[a] = '0;
        test_reset();
        test_single_pixel();
        test_frame_pattern();
        test_brightness_change();
        test_back_to_back();
        test_reset_midframe();
        test_long_plane();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/hub75_bcm_scan.md
HUB75_BCM_SCAN -- requirements
Module: hub75_bcm_scan

Interface
REQ-001 Parameter HPIXEL_P, default 64, panel width in pixels (columns shifted per line), >=2.
REQ-002 Parameter VPIXEL_P, default 64, panel height; even; scan rows SROWS = VPIXEL_P/2.
REQ-003 Parameter BPP_P, default 8, bits per colour channel = number of BCM bit planes, 1..8.
REQ-004 Derived: ROW_W = clog2(SROWS); ADDR_W = clog2(HPIXEL_P*SROWS); CNT_W = 8+BPP_P.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 i_en  in  1  level; high starts/continues frame scanning.
REQ-008 i_brightness  in  8  global brightness; sampled at frame start.
REQ-009 o_rd_addr  out  ADDR_W  framebuffer address = row*HPIXEL_P + col.
REQ-010 i_rd_data  in  2x3xBPP_P  [0]=top pixel (row r), [1]=bottom pixel (row r+SROWS), {R,G,B}; valid exactly 1 cycle after o_rd_addr.
REQ-011 O_CLK, STB, OE  out  1 each  HUB75 shift clock, latch strobe, output enable (active-low).
REQ-012 o_row  out  ROW_W  row select (replaces fixed A..E lines; bit0=A).
REQ-013 R1,G1,B1,R2,G2,B2  out  1 each  top/bottom colour bits of current plane.
REQ-014 o_busy  out  1  high whenever state != IDLE.
REQ-015 o_frame_done  out  1  single-cycle pulse at end of each frame.

Function
REQ-016 FSM states IDLE, PREFETCH, SHIFT, BLANK, LATCH, DISPLAY; scan order: for row 0..SROWS-1, for plane b 0..BPP_P-1: PREFETCH, SHIFT, BLANK, LATCH, DISPLAY.
REQ-017 IDLE -> PREFETCH on the cycle after i_en sampled high; i_brightness captured into br_q on that transition.
REQ-018 PREFETCH: 1 cycle, o_rd_addr = row*HPIXEL_P + 0.
REQ-019 SHIFT: 2*HPIXEL_P cycles, two per column c: phase A O_CLK=0, RGB outputs registered from bit b of i_rd_data; phase B O_CLK=1, o_rd_addr = address of column c+1 (held at last column when c=HPIXEL_P-1).
REQ-020 OE=1 in every state except DISPLAY; STB=0 except LATCH.
REQ-021 BLANK: 1 cycle, O_CLK=0, o_row updated to current row.
REQ-022 LATCH: 1 cycle, STB=1, O_CLK=0.
REQ-023 DISPLAY: OE=0 for exactly (br_q+1) << b cycles; CNT_W-bit counter, no overflow at br_q=255, b=7.
REQ-024 After DISPLAY: next plane, else next row at plane 0, else frame end.
REQ-025 Frame end: o_frame_done=1 during last DISPLAY cycle of row SROWS-1 plane BPP_P-1; then PREFETCH (row 0, br_q resampled) if i_en=1, else IDLE.
REQ-026 i_en deasserted mid-frame: current frame completes unchanged; IDLE only at frame end.
REQ-027 i_brightness changes mid-frame ignored until next frame start.
REQ-028 Cycles per plane = 3 + 2*HPIXEL_P + ((br_q+1)<<b).
REQ-029 RGB outputs hold last shifted value outside SHIFT.

Reset
REQ-030 rst_n low, any state: immediately IDLE, O_CLK=0, STB=0, OE=1, o_row=0, all RGB=0, o_rd_addr=0, o_busy=0, o_frame_done=0, row/plane/column/display counters=0, br_q=0.
REQ-031 After rst_n release, no output activity until i_en sampled high.

Verification
REQ-032 H=4,V=4,BPP=2, br=0, i_en held one frame then low: o_frame_done exactly 50 cycles after first PREFETCH cycle, returns IDLE, o_busy low.
REQ-033 Pixel (row1,col2) top = R 2'b10: R1=1 only on column 2 shift of row1 plane1; bus model matches every bit of all 16 pixels.
REQ-034 br=255, BPP=8, b=7: OE low for exactly 32768 cycles; STB precedes OE low by 1 cycle; o_row stable while OE=0.
REQ-035 i_brightness 0->3 mid-frame: current frame on-times use 0; next frame plane0 OE low 4 cycles.
REQ-036 rst_n asserted mid-SHIFT and mid-DISPLAY: outputs at REQ-030 values same cycle, no STB/OE glitch.
REQ-037 i_en held high: frames back-to-back, o_frame_done period constant, row 0 PREFETCH immediately follows frame end.
